// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract unit with valid/ready on both sides.
// Each stage finishes one slice; operands and partial sums are skewed to match.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4,
  parameter int GPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SW     = GROUP * GPS;
  localparam int STAGES = WIDTH / SW;

  if ((WIDTH % SW) != 0 || WIDTH < SW) begin : g_bad_params
    $error("WIDTH must be a multiple of GROUP*GPS");
  end

  logic              adv;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] co_d;
  logic              ovf_q;
  logic              ovf_d;

  assign adv       = !v_q[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

  function automatic logic [GROUP:0] cla(
    input logic [GROUP-1:0] p,
    input logic [GROUP-1:0] g,
    input logic             c0
  );
    logic [GROUP:0] c;
    logic           t;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      t = c0;
      for (int n = 0; n <= i; n++) t = t & p[n];
      c[i+1] = t;
      for (int m = 0; m <= i; m++) begin
        t = g[m];
        for (int n = m + 1; n <= i; n++) t = t & p[n];
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction

  // valid shift chain, inter-stage carries and the overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int j = STAGES - 1; j > 0; j--) v_q[j] <= v_q[j-1];
      v_q[0] <= in_valid;
      c_q    <= co_d;
      ovf_q  <= ovf_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic [SW-1:0] av;
    logic [SW-1:0] bv;
    logic [SW-1:0] sv;
    logic [SW-1:0] p;
    logic [SW-1:0] g;
    logic          ci;
    logic          co;
    logic [SW-1:0] sd_q [STAGES-k];

    if (k == 0) begin : g_head
      assign av = a[SW-1:0];
      assign bv = b[SW-1:0] ^ {SW{sub}};
      assign ci = sub | cin;
    end else begin : g_skew
      logic [SW-1:0] ad_q [k];
      logic [SW-1:0] bd_q [k];

      // hold this slice's operands until its stage comes up
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < k; i++) begin
            ad_q[i] <= '0;
            bd_q[i] <= '0;
          end
        end else if (adv) begin
          ad_q[0] <= a[k*SW +: SW];
          bd_q[0] <= b[k*SW +: SW] ^ {SW{sub}};
          for (int i = 1; i < k; i++) begin
            ad_q[i] <= ad_q[i-1];
            bd_q[i] <= bd_q[i-1];
          end
        end
      end

      assign av = ad_q[k-1];
      assign bv = bd_q[k-1];
      assign ci = c_q[k-1];
    end

    assign p = av ^ bv;
    assign g = av & bv;

    // lookahead inside each group, group carries rippled across the slice
    always_comb begin
      logic [GROUP:0] cv;
      logic           cc;
      cv = '0;
      cc = ci;
      sv = '0;
      for (int n = 0; n < GPS; n++) begin
        cv = cla(p[n*GROUP +: GROUP], g[n*GROUP +: GROUP], cc);
        sv[n*GROUP +: GROUP] = p[n*GROUP +: GROUP] ^ cv[GROUP-1:0];
        cc = cv[GROUP];
      end
      co = cc;
    end

    // finished slice waits here until the upper slices catch up
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < STAGES - k; i++) sd_q[i] <= '0;
      end else if (adv) begin
        sd_q[0] <= sv;
        for (int i = 1; i < STAGES - k; i++) sd_q[i] <= sd_q[i-1];
      end
    end

    assign s[k*SW +: SW] = sd_q[STAGES-k-1];
    assign co_d[k]       = co;

    if (k == STAGES - 1) begin : g_tail
      assign ovf_d = co ^ av[SW-1] ^ bv[SW-1] ^ sv[SW-1];
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (16-bit, 4-bit groups, 2 groups/stage).
// Results are compared against an arithmetic reference and fixed vectors.
module tb_pipelined_cla_adder;

  localparam int W   = 16;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4), .GPS(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [17:0] obs[$];
  logic [17:0] exp_q[$];
  int          obs_cyc[$];
  int          acc_cyc[$];

  logic         smp_ir;
  logic         smp_ov;
  logic [W-1:0] smp_s;

  // {cout, ovf, s} from plain integer arithmetic
  function automatic logic [17:0] model(
    input logic [15:0] x, input logic [15:0] y,
    input logic ci, input logic sb
  );
    int sx, sy, r, u;
    logic [15:0] sm;
    logic co, ov;
    sx = $signed(x);
    sy = $signed(y);
    if (sb) begin
      r  = sx - sy;
      co = (x >= y);
      sm = x - y;
    end else begin
      r  = sx + sy + int'(ci);
      u  = int'(x) + int'(y) + int'(ci);
      co = (u > 65535);
      sm = 16'(u);
    end
    ov = (r > 32767) || (r < -32768);
    return {co, ov, sm};
  endfunction

  task automatic clear_q();
    obs.delete(); exp_q.delete();
    obs_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic run_cycle(
    input logic iv, input logic [15:0] ia, input logic [15:0] ib,
    input logic ic, input logic isb, input logic ordy
  );
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; cin = ic; sub = isb;
    out_ready = ordy;
    #1;
    smp_ir = in_ready; smp_ov = out_valid; smp_s = s;
    if (out_valid && out_ready) begin
      obs.push_back({cout, ovf, s});
      obs_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(ia, ib, ic, isb));
      acc_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL por got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    rst = 1'b0;
    clear_q();
    run_cycle(1, 16'h1234, 16'h1111, 0, 0, 1);
    run_cycle(1, 16'h4321, 16'h2222, 0, 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight got ov=%b want 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || s !== '0 || cout !== 1'b0 ||
        ovf !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_rst got ov=%b s=%h c=%b o=%b ir=%b want 0 0 0 0 1",
               out_valid, s, cout, ovf, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    obs.delete();
    repeat (5) run_cycle(0, 0, 0, 0, 0, 1);
    n_chk++;
    if (obs.size() !== 0) begin
      n_fail++;
      $display("FAIL rst_flush got %0d outputs want 0", obs.size());
    end
  endtask

  task automatic test_add();
    clear_q();
    run_cycle(1, 16'h24D9, 16'h0C10, 0, 0, 1);
    run_cycle(1, 16'hFDE8, 16'h0C10, 0, 0, 1);
    repeat (4) run_cycle(0, 0, 0, 0, 0, 1);
    n_chk++;
    if (obs.size() !== 2) begin
      n_fail++;
      $display("FAIL add_cnt got %0d want 2", obs.size());
    end
    n_chk++;
    if (obs[0] !== {1'b0, 1'b0, 16'h30E9}) begin
      n_fail++;
      $display("FAIL add0 got %h want %h", obs[0], {1'b0, 1'b0, 16'h30E9});
    end
    n_chk++;
    if (obs[1] !== {1'b1, 1'b0, 16'h09F8}) begin
      n_fail++;
      $display("FAIL add1 got %h want %h", obs[1], {1'b1, 1'b0, 16'h09F8});
    end
    n_chk++;
    if (obs_cyc[0] - acc_cyc[0] !== LAT) begin
      n_fail++;
      $display("FAIL latency got %0d want %0d", obs_cyc[0] - acc_cyc[0], LAT);
    end
    n_chk++;
    if (obs_cyc[1] - obs_cyc[0] !== 1) begin
      n_fail++;
      $display("FAIL back_to_back got gap %0d want 1", obs_cyc[1] - obs_cyc[0]);
    end
  endtask

  task automatic test_sub();
    clear_q();
    run_cycle(1, 16'h0005, 16'h0007, 1, 1, 1);
    run_cycle(1, 16'h8000, 16'h0001, 0, 1, 1);
    repeat (4) run_cycle(0, 0, 0, 0, 0, 1);
    n_chk++;
    if (obs[0] !== {1'b0, 1'b0, 16'hFFFE}) begin
      n_fail++;
      $display("FAIL sub0 got %h want %h", obs[0], {1'b0, 1'b0, 16'hFFFE});
    end
    n_chk++;
    if (obs[1] !== {1'b1, 1'b1, 16'h7FFF}) begin
      n_fail++;
      $display("FAIL sub1 got %h want %h", obs[1], {1'b1, 1'b1, 16'h7FFF});
    end
  endtask

  task automatic test_ovf();
    clear_q();
    run_cycle(1, 16'h7FFF, 16'h0001, 0, 0, 1);
    run_cycle(1, 16'hFFFF, 16'h0000, 1, 0, 1);
    repeat (4) run_cycle(0, 0, 0, 0, 0, 1);
    n_chk++;
    if (obs[0] !== {1'b0, 1'b1, 16'h8000}) begin
      n_fail++;
      $display("FAIL ovf0 got %h want %h", obs[0], {1'b0, 1'b1, 16'h8000});
    end
    n_chk++;
    if (obs[1] !== {1'b1, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL chain1 got %h want %h", obs[1], {1'b1, 1'b0, 16'h0000});
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] oa [8];
    logic [15:0] ob [8];
    logic        oc [8];
    logic        os [8];
    logic [W-1:0] hold;
    int idx;
    idx = 0;
    hold = '0;
    clear_q();
    for (int i = 0; i < 8; i++) begin
      oa[i] = 16'($urandom); ob[i] = 16'($urandom);
      oc[i] = 1'($urandom); os[i] = 1'($urandom);
    end
    for (int c = 0; c < 20; c++) begin
      if (idx < 8)
        run_cycle(1, oa[idx], ob[idx], oc[idx], os[idx], !(c >= 3 && c <= 6));
      else
        run_cycle(0, 0, 0, 0, 0, 1);
      if (c == 3) hold = smp_s;
      if (c >= 3 && c <= 6) begin
        n_chk++;
        if (smp_ir !== 1'b0 || smp_ov !== 1'b1 || smp_s !== hold) begin
          n_fail++;
          $display("FAIL stall c=%0d got ir=%b ov=%b s=%h want 0 1 %h",
                   c, smp_ir, smp_ov, smp_s, hold);
        end
      end
      if (idx < 8 && smp_ir) idx++;
    end
    n_chk++;
    if (obs.size() !== 8) begin
      n_fail++;
      $display("FAIL bp_cnt got %0d want 8", obs.size());
    end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (obs[i] !== model(oa[i], ob[i], oc[i], os[i])) begin
        n_fail++;
        $display("FAIL bp_order i=%0d got %h want %h",
                 i, obs[i], model(oa[i], ob[i], oc[i], os[i]));
      end
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int i = 0; i < 10000; i++)
      run_cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    repeat (6) run_cycle(0, 0, 0, 0, 0, 1);
    n_chk++;
    if (obs.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_cnt got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand i=%0d got %h want %h", i, obs[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_ovf();
    test_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
